// File: rtl/writebuffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : writebuffer_pkg
// Brief   : Shared memory-side definitions for the write buffer: sequencer
//           state encodings, memory direction codes, default address width.
// Revision: 1.0 - initial release
// ============================================================================
package writebuffer_pkg;

    // Default word-address width, matching memadr
    localparam int c_ADRW_DEFAULT = 27;

    // memrwb direction codes
    localparam logic c_MEM_READ  = 1'b1;
    localparam logic c_MEM_WRITE = 1'b0;

    // Memory sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RDONE = 2'd3
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/writebuffer_wbfifo.sv
`default_nettype none
// ============================================================================
// Module  : wbfifo
// Brief   : Posted-write storage for the write buffer. Circular FIFO of
//           {adr, data, byteen} with registered full/empty and a parallel
//           address compare of every valid entry against the read address.
// Revision: 1.0 - initial release
// ============================================================================
module wbfifo
    import writebuffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADRW  = c_ADRW_DEFAULT
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic            enq,
    input  logic [ADRW-1:0] enq_adr,
    input  logic [31:0]     enq_data,
    input  logic [3:0]      enq_be,
    input  logic            deq,
    input  logic [ADRW-1:0] cmp_adr,
    output logic [ADRW-1:0] head_adr,
    output logic [31:0]     head_data,
    output logic [3:0]      head_be,
    output logic            hazard,
    output logic            full,
    output logic            empty
);

    localparam int c_PTRW = $clog2(DEPTH);
    localparam int c_CNTW = $clog2(DEPTH + 1);

    logic [ADRW-1:0]   r_adr  [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [3:0]        r_be   [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [c_PTRW-1:0] r_head;
    logic [c_PTRW-1:0] r_tail;
    logic [c_CNTW-1:0] r_count;
    logic              r_full;
    logic              r_empty;
    logic [c_CNTW-1:0] w_count_nxt;
    logic              w_enq;
    logic              w_deq;
    logic [DEPTH-1:0]  w_match;

    // A full buffer refuses writes even when a dequeue lands on the same edge
    assign w_enq = enq && !r_full;
    assign w_deq = deq && !r_empty;

    // Occupancy after this edge; simultaneous enqueue and dequeue cancel
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + c_CNTW'(1);
            2'b01:   w_count_nxt = r_count - c_CNTW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry payload storage; needs no reset because r_valid gates its use
    always_ff @(posedge ph1) begin
        if (w_enq) begin
            r_adr[r_tail]  <= enq_adr;
            r_data[r_tail] <= enq_data;
            r_be[r_tail]   <= enq_be;
        end
    end

    // Pointers, valid flags, count and status flags
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_enq) begin
                r_tail          <= r_tail + c_PTRW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_deq) begin
                r_head          <= r_head + c_PTRW'(1);
                r_valid[r_head] <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNTW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Every valid entry, including the one in flight, is compared
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_match[gi] = r_valid[gi] && (r_adr[gi] == cmp_adr);
    end

    assign hazard    = |w_match;
    assign head_adr  = r_adr[r_head];
    assign head_data = r_data[r_head];
    assign head_be   = r_be[r_head];
    assign full      = r_full;
    assign empty     = r_empty;

endmodule
`default_nettype wire

// File: rtl/writebuffer.sv
`default_nettype none
// ============================================================================
// Module  : writebuffer
// Brief   : Posted-write buffer and main-memory sequencer. Queues cache
//           write-through stores and issues line-fill reads, holding a read
//           back only while a queued write targets the same address.
// Revision: 1.0 - initial release
// ============================================================================
module writebuffer
    import writebuffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADRW  = c_ADRW_DEFAULT
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic            cwrite,
    input  logic            cread,
    input  logic [ADRW-1:0] cadr,
    input  logic [31:0]     cwdata,
    input  logic [3:0]      cbyteen,
    output logic            cwack,
    output logic [31:0]     crdata,
    output logic            crdone,
    output logic            full,
    output logic            empty,
    output logic [ADRW-1:0] memadr,
    output logic [31:0]     memwdata,
    output logic [3:0]      membyteen,
    output logic            memrwb,
    output logic            memen,
    input  logic [31:0]     memrdata,
    input  logic            memdone
);

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    logic            r_memen,     w_memen_nxt;
    logic            r_memrwb,    w_memrwb_nxt;
    logic [ADRW-1:0] r_memadr,    w_memadr_nxt;
    logic [31:0]     r_memwdata,  w_memwdata_nxt;
    logic [3:0]      r_membyteen, w_membyteen_nxt;
    logic [31:0]     r_crdata,    w_crdata_nxt;
    logic            r_crdone,    w_crdone_nxt;
    logic            w_deq;
    logic            w_hazard;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [ADRW-1:0] w_head_adr;
    logic [31:0]     w_head_data;
    logic [3:0]      w_head_be;

    wbfifo #(
        .DEPTH (DEPTH),
        .ADRW  (ADRW)
    ) u_fifo (
        .ph1       (ph1),
        .reset     (reset),
        .enq       (cwrite),
        .enq_adr   (cadr),
        .enq_data  (cwdata),
        .enq_be    (cbyteen),
        .deq       (w_deq),
        .cmp_adr   (cadr),
        .head_adr  (w_head_adr),
        .head_data (w_head_data),
        .head_be   (w_head_be),
        .hazard    (w_hazard),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Sequencer: next state and next memory-side register values
    always_comb begin
        w_state_nxt     = r_state;
        w_memen_nxt     = r_memen;
        w_memrwb_nxt    = r_memrwb;
        w_memadr_nxt    = r_memadr;
        w_memwdata_nxt  = r_memwdata;
        w_membyteen_nxt = r_membyteen;
        w_crdata_nxt    = r_crdata;
        w_crdone_nxt    = 1'b0;
        w_deq           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A read that misses the buffer overtakes queued writes
                if (cread && !w_hazard) begin
                    w_state_nxt  = ST_READ;
                    w_memadr_nxt = cadr;
                    w_memrwb_nxt = c_MEM_READ;
                    w_memen_nxt  = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_state_nxt     = ST_WRITE;
                    w_memadr_nxt    = w_head_adr;
                    w_memwdata_nxt  = w_head_data;
                    w_membyteen_nxt = w_head_be;
                    w_memrwb_nxt    = c_MEM_WRITE;
                    w_memen_nxt     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (memdone) begin
                    w_deq       = 1'b1;
                    w_memen_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (memdone) begin
                    w_crdata_nxt = memrdata;
                    w_crdone_nxt = 1'b1;
                    w_memen_nxt  = 1'b0;
                    w_state_nxt  = ST_RDONE;
                end
            end
            ST_RDONE: begin
                // Idle one cycle so the controller can drop cread
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered memory/cache-side outputs
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_memen     <= 1'b0;
            r_memrwb    <= c_MEM_READ;
            r_memadr    <= '0;
            r_memwdata  <= '0;
            r_membyteen <= '0;
            r_crdata    <= '0;
            r_crdone    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_memen     <= w_memen_nxt;
            r_memrwb    <= w_memrwb_nxt;
            r_memadr    <= w_memadr_nxt;
            r_memwdata  <= w_memwdata_nxt;
            r_membyteen <= w_membyteen_nxt;
            r_crdata    <= w_crdata_nxt;
            r_crdone    <= w_crdone_nxt;
        end
    end

    assign cwack     = !w_fifo_full;
    assign full      = w_fifo_full;
    assign empty     = w_fifo_empty;
    assign memen     = r_memen;
    assign memrwb    = r_memrwb;
    assign memadr    = r_memadr;
    assign memwdata  = r_memwdata;
    assign membyteen = r_membyteen;
    assign crdata    = r_crdata;
    assign crdone    = r_crdone;

endmodule
`default_nettype wire

// File: tb/tb_writebuffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_writebuffer
// Brief   : Self-checking bench for writebuffer: queue-based reference model
//           compared every cycle, plus directed transaction-order checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_writebuffer;

    localparam int DEPTH = 4;
    localparam int ADRW  = 27;

    typedef struct packed {
        logic            rwb;
        logic [ADRW-1:0] adr;
        logic [31:0]     data;
        logic [3:0]      be;
    } txn_t;

    logic            ph1     = 1'b0;
    logic            reset   = 1'b0;
    logic            cwrite  = 1'b0;
    logic            cread   = 1'b0;
    logic [ADRW-1:0] cadr    = '0;
    logic [31:0]     cwdata  = '0;
    logic [3:0]      cbyteen = '0;
    logic [31:0]     memrdata = '0;
    logic            memdone  = 1'b0;
    logic            cwack, crdone, full, empty, memrwb, memen;
    logic [31:0]     crdata, memwdata;
    logic [ADRW-1:0] memadr;
    logic [3:0]      membyteen;

    writebuffer #(.DEPTH(DEPTH), .ADRW(ADRW)) dut (
        .ph1(ph1), .reset(reset), .cwrite(cwrite), .cread(cread), .cadr(cadr),
        .cwdata(cwdata), .cbyteen(cbyteen), .cwack(cwack), .crdata(crdata),
        .crdone(crdone), .full(full), .empty(empty), .memadr(memadr),
        .memwdata(memwdata), .membyteen(membyteen), .memrwb(memrwb),
        .memen(memen), .memrdata(memrdata), .memdone(memdone)
    );

    always #5 ph1 = ~ph1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rd_pat(input logic [ADRW-1:0] a);
        return 32'hA500_0000 | {8'h00, a[23:0]};
    endfunction

    // ---------------- memory responder ----------------
    logic mem_hold = 1'b0;
    int   mem_lat  = 1;
    bit   lat_rand = 1'b0;
    int   lat_cnt  = 0;
    int   cur_lat  = 1;
    txn_t mlog[$];

    initial begin
        txn_t t;
        forever begin
            @(posedge ph1); #1;
            if (reset || !memen) begin
                memdone = 1'b0;
                lat_cnt = 0;
            end else if (!memdone) begin
                if (lat_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(4, 1)) : mem_lat;
                lat_cnt++;
                if (!mem_hold && lat_cnt >= cur_lat) begin
                    memrdata = rd_pat(memadr);
                    memdone  = 1'b1;
                    t.rwb  = memrwb;
                    t.adr  = memadr;
                    t.data = memrwb ? rd_pat(memadr) : memwdata;
                    t.be   = membyteen;
                    mlog.push_back(t);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Buffer as a queue; one outstanding memory request; one quiet cycle after a read.
    txn_t        mq[$];
    int          m_busy   = 0;       // 0 none, 1 write, 2 read
    bit          m_gap    = 1'b0;
    txn_t        m_cur;
    logic [31:0] m_crdata = '0;
    bit          m_crdone = 1'b0;

    initial begin
        bit   acc, haz;
        txn_t e;
        m_cur = '0;
        forever begin
            @(posedge ph1 or posedge reset);
            if (reset) begin
                mq.delete();
                m_busy = 0; m_gap = 1'b0; m_crdata = '0; m_crdone = 1'b0;
            end else begin
                acc = cwrite && (mq.size() < DEPTH);
                haz = 1'b0;
                foreach (mq[i]) if (mq[i].adr == cadr) haz = 1'b1;
                m_crdone = 1'b0;
                if (m_gap) begin
                    m_gap = 1'b0;
                end else if (m_busy == 1) begin
                    if (memdone) begin
                        void'(mq.pop_front());
                        m_busy = 0;
                    end
                end else if (m_busy == 2) begin
                    if (memdone) begin
                        m_crdata = memrdata;
                        m_crdone = 1'b1;
                        m_gap    = 1'b1;
                        m_busy   = 0;
                    end
                end else if (cread && !haz) begin
                    m_busy = 2;
                    m_cur.rwb = 1'b1;
                    m_cur.adr = cadr;
                end else if (mq.size() > 0) begin
                    m_busy = 1;
                    m_cur  = mq[0];
                end
                if (acc) begin
                    e.rwb = 1'b0; e.adr = cadr; e.data = cwdata; e.be = cbyteen;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en     = 1'b0;
    int n_crdone   = 0;
    int n_memen_hi = 0;

    initial forever begin
        @(negedge ph1);
        if (crdone) n_crdone++;
        if (memen)  n_memen_hi++;
        if (cmp_en) begin
            chk("memen", memen, m_busy != 0);
            if (m_busy != 0) begin
                chk("memrwb", memrwb, m_cur.rwb);
                chk("memadr", memadr, m_cur.adr);
                if (m_busy == 1) begin
                    chk("memwdata", memwdata, m_cur.data);
                    chk("membyteen", membyteen, m_cur.be);
                end
            end
            chk("crdone", crdone, m_crdone);
            chk("crdata", crdata, m_crdata);
            chk("full",   full,   mq.size() == DEPTH);
            chk("empty",  empty,  mq.size() == 0);
            chk("cwack",  cwack,  mq.size() != DEPTH);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ph1); #1;
    endtask

    task automatic do_write(input logic [ADRW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bit ok, done;
        done = 1'b0;
        cadr = a; cwdata = d; cbyteen = be; cwrite = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            ok = cwack;
            tick();
            if (ok) done = 1'b1;
        end
        cwrite = 1'b0;
        if (!done) chk("write_accept_timeout", 0, 1);
    endtask

    task automatic start_read(input logic [ADRW-1:0] a);
        cadr = a; cread = 1'b1;
    endtask

    task automatic finish_read(output logic [31:0] d);
        bit done;
        done = 1'b0;
        d = '0;
        for (int t = 0; t < 500 && !done; t++) begin
            tick();
            if (crdone) begin
                d = crdata;
                done = 1'b1;
            end
        end
        cread = 1'b0;
        if (!done) chk("read_done_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            tick();
            if (empty && !memen) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_txn(input string name, input int idx, input logic rwb,
                           input logic [ADRW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        if (idx >= mlog.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_rwb"}, mlog[idx].rwb, rwb);
            chk({name, "_adr"}, mlog[idx].adr, a);
            chk({name, "_data"}, mlog[idx].data, d);
            if (!rwb) chk({name, "_be"}, mlog[idx].be, be);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          base, cr0;
        logic [31:0] rd;
        txn_t        exp_q[$];
        txn_t        e;

        // Reset values
        #2 reset = 1'b1;
        #1;
        chk("rst_cwack", cwack, 1);
        chk("rst_memen", memen, 0);
        chk("rst_memrwb", memrwb, 1);
        chk("rst_memadr", memadr, 0);
        chk("rst_memwdata", memwdata, 0);
        chk("rst_membyteen", membyteen, 0);
        chk("rst_crdata", crdata, 0);
        chk("rst_crdone", crdone, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        repeat (2) @(posedge ph1);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        // Single write, memory answers 3 cycles after memen
        mem_lat = 3;
        base = mlog.size();
        do_write(27'h10, 32'hDEAD_BEEF, 4'b0011);
        chk("wr_not_yet_issued", memen, 0);
        tick();
        chk("wr_issued", memen, 1);
        wait_drain();
        chk("wr_count", mlog.size(), base + 1);
        chk_txn("wr", base, 1'b0, 27'h10, 32'hDEAD_BEEF, 4'b0011);
        chk("wr_empty", empty, 1);

        // Fill and back-pressure
        mem_lat  = 1;
        mem_hold = 1'b1;
        base = mlog.size();
        for (int i = 1; i <= 4; i++) do_write(27'h100 + 27'(i), 32'h1111_1111 * i, 4'hF);
        chk("fill_full", full, 1);
        chk("fill_cwack", cwack, 0);
        mem_hold = 1'b0;
        do_write(27'h105, 32'h5555_5555, 4'hA);
        wait_drain();
        chk("fill_count", mlog.size(), base + 5);
        for (int i = 1; i <= 4; i++)
            chk_txn("fill", base + i - 1, 1'b0, 27'h100 + 27'(i), 32'h1111_1111 * i, 4'hF);
        chk_txn("fill5", base + 4, 1'b0, 27'h105, 32'h5555_5555, 4'hA);

        // Non-hazard read latency
        base = mlog.size();
        start_read(27'h77);
        tick();
        chk("rd_issued", memen, 1);
        chk("rd_rwb", memrwb, 1);
        finish_read(rd);
        chk("rd_data", rd, 32'hA500_0077);
        wait_drain();

        // Read bypass of queued writes
        mem_hold = 1'b1;
        base = mlog.size();
        cr0  = n_crdone;
        do_write(27'h1F, 32'h1F1F_1F1F, 4'hF);
        do_write(27'h20, 32'h2020_2020, 4'hC);
        do_write(27'h21, 32'h2121_2121, 4'h3);
        start_read(27'h30);
        tick();
        mem_hold = 1'b0;
        finish_read(rd);
        wait_drain();
        chk("byp_data", rd, 32'hA500_0030);
        chk("byp_crdone_once", n_crdone - cr0, 1);
        chk("byp_crdata_hold", crdata, 32'hA500_0030);
        chk_txn("byp0", base,     1'b0, 27'h1F, 32'h1F1F_1F1F, 4'hF);
        chk_txn("byp1", base + 1, 1'b1, 27'h30, 32'hA500_0030, 4'h0);
        chk_txn("byp2", base + 2, 1'b0, 27'h20, 32'h2020_2020, 4'hC);
        chk_txn("byp3", base + 3, 1'b0, 27'h21, 32'h2121_2121, 4'h3);

        // RAW hazard
        base = mlog.size();
        do_write(27'h40, 32'h1234_5678, 4'hF);
        start_read(27'h40);
        finish_read(rd);
        wait_drain();
        chk("raw_data", rd, 32'hA500_0040);
        chk_txn("raw0", base,     1'b0, 27'h40, 32'h1234_5678, 4'hF);
        chk_txn("raw1", base + 1, 1'b1, 27'h40, 32'hA500_0040, 4'h0);

        // Reset mid-transaction
        mem_hold = 1'b1;
        do_write(27'h60, 32'h6060_6060, 4'hF);
        do_write(27'h61, 32'h6161_6161, 4'hF);
        do_write(27'h62, 32'h6262_6262, 4'hF);
        chk("rmt_busy", memen, 1);
        base = mlog.size();
        @(posedge ph1);
        #3 reset = 1'b1;
        #1;
        chk("rmt_memen_drop", memen, 0);
        chk("rmt_empty", empty, 1);
        chk("rmt_full", full, 0);
        tick();
        tick();
        reset = 1'b0;
        mem_hold = 1'b0;
        n_memen_hi = 0;
        repeat (20) tick();
        chk("rmt_no_txn", mlog.size(), base);
        chk("rmt_no_memen", n_memen_hi, 0);

        // Illegal cread + cwrite together
        base = mlog.size();
        cadr = 27'h50; cwdata = 32'h5050_5050; cbyteen = 4'hF;
        cwrite = 1'b1; cread = 1'b1;
        tick();
        cwrite = 1'b0;
        chk("ill_enqueued", empty, 0);
        chk("ill_read_first", memrwb, 1);
        finish_read(rd);
        wait_drain();
        chk_txn("ill0", base,     1'b1, 27'h50, 32'hA500_0050, 4'h0);
        chk_txn("ill1", base + 1, 1'b0, 27'h50, 32'h5050_5050, 4'hF);

        // Random writes with random latency: pointer wrap shows as data order
        lat_rand = 1'b1;
        base = mlog.size();
        for (int i = 0; i < 20; i++) begin
            e.rwb  = 1'b0;
            e.adr  = 27'h200 + 27'(i);
            e.data = $urandom;
            e.be   = 4'($urandom_range(15, 1));
            exp_q.push_back(e);
            do_write(e.adr, e.data, e.be);
            if ($urandom_range(3, 0) == 0) tick();
        end
        wait_drain();
        lat_rand = 1'b0;
        chk("rnd_count", mlog.size(), base + 20);
        foreach (exp_q[i]) chk_txn("rnd", base + i, 1'b0, exp_q[i].adr, exp_q[i].data, exp_q[i].be);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
